cordic_pipe: RTL and testbench

//  Parametrised, fully pipelined fixed-point CORDIC engine with per-sample rotation/vectoring mode.

---
 rtl/cordic_pipe_if.sv | 30 +++
 rtl/cordic_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_cordic_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_pipe_if.sv
// Valid/ready stream bundle for cordic_pipe: one operand channel in, one result channel out.
// The slave modport is the engine's view; the master modport is the feeding/consuming side.
interface cordic_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] in_x;
  logic signed [WIDTH-1:0] in_y;
  logic signed [WIDTH-1:0] in_z;
  logic [TAG_W-1:0]        in_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] out_z;
  logic [TAG_W-1:0]        out_tag;

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_tag
  );
endinterface

// File: rtl/cordic_pipe.sv
// Fully pipelined CORDIC, per-sample rotation/vectoring, global stall on out_valid & ~out_ready.
// Optional macro CORDIC_GAIN_COMP_EN adds a 1/K scaling stage (latency STAGES+3 instead of STAGES+2).
module cordic_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 14,
  parameter int TAG_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  cordic_pipe_if.slave  s
);

  localparam int IW = WIDTH + 2;
  localparam int SH = 64 - WIDTH;
  typedef logic signed [IW-1:0] ival_t;

  // atan(1/n) as a 2^-125 fixed-point alternating series, evaluated at elaboration only
  function automatic logic [127:0] atan_inv_q(input logic [127:0] n);
    logic [127:0] p, sum;
    p   = (128'd1 << 125) / n;
    sum = '0;
    for (int k = 0; k < 64; k++) begin
      if (k % 2 == 0) sum = sum + p / 128'(2 * k + 1);
      else            sum = sum - p / 128'(2 * k + 1);
      p = p / (n * n);
    end
    return sum;
  endfunction

  function automatic logic [47:0][63:0] build_atan_tab();
    logic [47:0][63:0] t;
    logic [127:0]      a;
    for (int i = 0; i < 48; i++) begin
      if (i == 0) a = atan_inv_q(128'd2) + atan_inv_q(128'd3);
      else        a = atan_inv_q(128'd1 << i);
      t[i] = 64'((a + (128'd1 << 63)) >> 64);
    end
    return t;
  endfunction

  localparam logic [47:0][63:0] ATAN_TAB = build_atan_tab();

  function automatic logic [STAGES-1:0][WIDTH-1:0] build_atan_w();
    logic [STAGES-1:0][WIDTH-1:0] t;
    for (int i = 0; i < STAGES; i++)
      t[i] = WIDTH'((ATAN_TAB[i] + (64'd1 << (SH - 1))) >> SH);
    return t;
  endfunction

  localparam logic [STAGES-1:0][WIDTH-1:0] ATAN_W = build_atan_w();
  localparam logic signed [WIDTH-1:0] PI_2 =
    WIDTH'(((ATAN_TAB[0] << 1) + (64'd1 << (SH - 1))) >> SH);

  function automatic logic signed [WIDTH-1:0] sat(input ival_t v);
    if (&v[IW-1:WIDTH-1] || ~|v[IW-1:WIDTH-1]) return v[WIDTH-1:0];
    return v[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  logic                    w_ce;
  logic [STAGES:0]         r_v;
  ival_t                   r_x [STAGES+1];
  ival_t                   r_y [STAGES+1];
  logic signed [WIDTH-1:0] r_z [STAGES+1];
  logic [TAG_W-1:0]        r_t [STAGES+1];
  logic [STAGES:0]         r_zf;
  logic [STAGES-1:0]       r_m;

  logic                    r_ov;
  logic signed [WIDTH-1:0] r_ox, r_oy, r_oz;
  logic [TAG_W-1:0]        r_ot;

  ival_t                   w_ix, w_iy, w_px, w_py;
  logic signed [WIDTH-1:0] w_pz;
  logic                    w_zf;
  logic [STAGES-1:0]       w_dpos;
  ival_t                   w_nx [STAGES];
  ival_t                   w_ny [STAGES];
  logic signed [WIDTH-1:0] w_nz [STAGES];

  logic                    w_lv, w_lzf;
  ival_t                   w_lx, w_ly;
  logic signed [WIDTH-1:0] w_lz;
  logic [TAG_W-1:0]        w_lt;

  assign w_ce        = ~r_ov | s.out_ready;
  assign s.in_ready  = w_ce;
  assign s.out_valid = r_ov;
  assign s.out_x     = r_ox;
  assign s.out_y     = r_oy;
  assign s.out_z     = r_oz;
  assign s.out_tag   = r_ot;

  assign w_ix = ival_t'(s.in_x);
  assign w_iy = ival_t'(s.in_y);
  // Zero vector has no defined angle; its z is forced to 0 at the output.
  assign w_zf = s.in_mode & (s.in_x == '0) & (s.in_y == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_px = w_ix;
    w_py = w_iy;
    w_pz = s.in_z;
    if (!s.in_mode) begin
      if (s.in_z > PI_2) begin
        w_px = -w_iy;  w_py = w_ix;  w_pz = s.in_z - PI_2;
      end else if (s.in_z < -PI_2) begin
        w_px = w_iy;   w_py = -w_ix; w_pz = s.in_z + PI_2;
      end
    end else begin
      w_pz = '0;
      if (w_ix[IW-1]) begin
        if (!w_iy[IW-1]) begin
          w_px = w_iy;  w_py = -w_ix; w_pz = PI_2;
        end else begin
          w_px = -w_iy; w_py = w_ix;  w_pz = -PI_2;
        end
      end
    end
  end

  // NOTE: combinational logic uses blocking '='; only clocked state uses '<='.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      w_dpos[i] = r_m[i] ? r_y[i][IW-1] : ~r_z[i][WIDTH-1];
      w_nx[i]   = w_dpos[i] ? r_x[i] - (r_y[i] >>> i) : r_x[i] + (r_y[i] >>> i);
      w_ny[i]   = w_dpos[i] ? r_y[i] + (r_x[i] >>> i) : r_y[i] - (r_x[i] >>> i);
      w_nz[i]   = w_dpos[i] ? r_z[i] - $signed(ATAN_W[i]) : r_z[i] + $signed(ATAN_W[i]);
    end
  end

  // NOTE: the datapath shift registers carry no reset; only valids and outputs need a known state.
  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_x[0]  <= w_px;
      r_y[0]  <= w_py;
      r_z[0]  <= w_pz;
      r_t[0]  <= s.in_tag;
      r_zf[0] <= w_zf;
      r_m[0]  <= s.in_mode;
      r_m[STAGES-1:1] <= r_m[STAGES-2:0];
      for (int i = 0; i < STAGES; i++) begin
        r_x[i+1]  <= w_nx[i];
        r_y[i+1]  <= w_ny[i];
        r_z[i+1]  <= w_nz[i];
        r_t[i+1]  <= r_t[i];
        r_zf[i+1] <= r_zf[i];
      end
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int PW = IW + WIDTH + 2;
  localparam logic [WIDTH:0] INV_K = (WIDTH+1)'(longint'(0.607253 * (2.0 ** WIDTH)));
  localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (WIDTH - 1));

  logic                    r_gv, r_gzf;
  ival_t                   r_gx, r_gy;
  logic signed [WIDTH-1:0] r_gz;
  logic [TAG_W-1:0]        r_gt;
  logic signed [PW-1:0]    w_mx, w_my;

  assign w_mx = PW'(r_x[STAGES]) * PW'($signed({1'b0, INV_K}));
  assign w_my = PW'(r_y[STAGES]) * PW'($signed({1'b0, INV_K}));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    r_gv <= 1'b0;
    else if (w_ce) r_gv <= r_v[STAGES];
  end

  always_ff @(posedge clk) begin
    if (w_ce) begin
      r_gx  <= ival_t'((w_mx + HALF) >>> WIDTH);
      r_gy  <= ival_t'((w_my + HALF) >>> WIDTH);
      r_gz  <= r_z[STAGES];
      r_gt  <= r_t[STAGES];
      r_gzf <= r_zf[STAGES];
    end
  end

  assign w_lv  = r_gv;
  assign w_lx  = r_gx;
  assign w_ly  = r_gy;
  assign w_lz  = r_gz;
  assign w_lt  = r_gt;
  assign w_lzf = r_gzf;
`else
  assign w_lv  = r_v[STAGES];
  assign w_lx  = r_x[STAGES];
  assign w_ly  = r_y[STAGES];
  assign w_lz  = r_z[STAGES];
  assign w_lt  = r_t[STAGES];
  assign w_lzf = r_zf[STAGES];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v  <= '0;
      r_ov <= 1'b0;
      r_ox <= '0;
      r_oy <= '0;
      r_oz <= '0;
      r_ot <= '0;
    end else if (w_ce) begin
      r_v  <= {r_v[STAGES-1:0], s.in_valid};
      r_ov <= w_lv;
      r_ox <= sat(w_lx);
      r_oy <= sat(w_ly);
      r_oz <= w_lzf ? '0 : w_lz;
      r_ot <= w_lt;
    end
  end

endmodule

// File: tb/tb_cordic_pipe.sv
// Scoreboard bench for cordic_pipe: directed vectors, a random stalled stream against a real-valued
// model, and a mid-stream reset. Define CORDIC_GAIN_COMP_EN for both DUT and bench to cover that build.
module tb_cordic_pipe;

  localparam int WIDTH  = 16;
  localparam int STAGES = 14;
  localparam int TAG_W  = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT       = STAGES + 3;
  localparam real OUT_SCALE = 0.607253;
`else
  localparam int  LAT       = STAGES + 2;
  localparam real OUT_SCALE = 1.0;
`endif

  typedef struct {
    int x, y, z, tag;
    int tx, ty, tz;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cordic_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) ifc ();

  cordic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (ifc)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int obs, input int exp, input int tol);
    n_checks++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, obs, exp, tol, $time);
    end
  endtask

  function automatic real k_gain();
    real k = 1.0;
    for (int i = 0; i < STAGES; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    return k;
  endfunction

  function automatic int sat_r(input real r);
    int v = int'(r);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic exp_t model(input bit mode, input int x, input int y, input int z, input int tag);
    exp_t e;
    real  g, zr, rx, ry;
    g  = k_gain() * OUT_SCALE;
    rx = real'(x);
    ry = real'(y);
    e.tag = tag;
    e.tx  = 8;
    e.ty  = 8;
    if (!mode) begin
      zr   = real'(z) / 8192.0;
      e.x  = sat_r(g * (rx * $cos(zr) - ry * $sin(zr)));
      e.y  = sat_r(g * (rx * $sin(zr) + ry * $cos(zr)));
      e.z  = 0;
      e.tz = 4;
    end else begin
      e.x  = sat_r(g * $sqrt(rx * rx + ry * ry));
      e.y  = 0;
      e.z  = int'($atan2(ry, rx) * 8192.0);
      e.tz = 8;
    end
    return e;
  endfunction

  task automatic drive(input bit mode, input int x, input int y, input int z, input int tag);
    ifc.in_mode = mode;
    ifc.in_x    = WIDTH'(x);
    ifc.in_y    = WIDTH'(y);
    ifc.in_z    = WIDTH'(z);
    ifc.in_tag  = TAG_W'(tag);
  endtask

  // One sample through an otherwise empty pipeline, with latency measured in clock edges.
  task automatic run_single(input string name, input bit mode, input int x, input int y, input int z,
                            input int tag, input int ex, input int ey, input int ez,
                            input int tx, input int ty, input int tz);
    int lat;
    @(negedge clk);
    drive(mode, x, y, z, tag);
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, int'(ifc.in_ready), 1, 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    while (!ifc.out_valid && lat < 4 * LAT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({name, "_latency"}, lat, LAT, 0);
    check({name, "_x"}, int'(ifc.out_x), ex, tx);
    check({name, "_y"}, int'(ifc.out_y), ey, ty);
    check({name, "_z"}, int'(ifc.out_z), ez, tz);
    check({name, "_tag"}, int'(ifc.out_tag), tag, 0);
  endtask

  task automatic random_stream(input int total);
    int   sent = 0, got = 0, cyc = 0, x, y, z;
    bit   have = 1'b0, mode;
    exp_t e, cur;
    while ((sent < total || sb.size() > 0) && cyc < 40 * total) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < total && $urandom_range(3, 0) != 0) begin
        mode = 1'($urandom_range(1, 0));
        if (!mode) begin
          x = int'($urandom_range(6000, 0)) - 3000;
          y = int'($urandom_range(6000, 0)) - 3000;
          z = int'($urandom_range(51472, 0)) - 25736;
        end else begin
          x = 5000; y = -2000; z = 0;
          for (int t = 0; t < 100; t++) begin
            x = int'($urandom_range(16000, 0)) - 8000;
            y = int'($urandom_range(16000, 0)) - 8000;
            if (x * x + y * y >= 9000000) break;
          end
          if (x * x + y * y < 9000000) begin x = 5000; y = -2000; end
          z = int'($urandom_range(65535, 0)) - 32768;
        end
        drive(mode, x, y, z, sent % 16);
        cur  = model(mode, x, y, z, sent % 16);
        have = 1'b1;
      end
      ifc.in_valid  = have;
      ifc.out_ready = 1'($urandom_range(1, 0));
      #1;
      check("stall_in_ready", int'(ifc.in_ready), int'(!(ifc.out_valid && !ifc.out_ready)), 0);
      if (ifc.out_valid && ifc.out_ready) begin
        got++;
        if (sb.size() == 0) begin
          check("rand_unexpected_output", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          check("rand_x", int'(ifc.out_x), e.x, e.tx);
          check("rand_y", int'(ifc.out_y), e.y, e.ty);
          check("rand_z", int'(ifc.out_z), e.z, e.tz);
          check("rand_tag", int'(ifc.out_tag), e.tag, 0);
        end
      end
      if (ifc.in_valid && ifc.in_ready) begin
        sb.push_back(cur);
        sent++;
        have = 1'b0;
      end
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check("rand_sent", sent, total, 0);
    check("rand_received", got, total, 0);
  endtask

  initial begin
    int ov_seen;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    drive(1'b0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(ifc.out_valid), 0, 0);
    check("rst_out_x", int'(ifc.out_x), 0, 0);
    check("rst_out_y", int'(ifc.out_y), 0, 0);
    check("rst_out_z", int'(ifc.out_z), 0, 0);
    check("rst_out_tag", int'(ifc.out_tag), 0, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(ifc.in_ready), 1, 0);

    run_single("rot_0", 1'b0, 9949, 0, 0, 3,
               int'(16384 * OUT_SCALE), 0, 0, 4, 4, 4);
    run_single("rot_pi2", 1'b0, 9949, 0, 12868, 5,
               0, int'(16384 * OUT_SCALE), 0, 4, 4, 4);
    run_single("rot_mpi", 1'b0, 9949, 0, -25736, 6,
               int'(-16384 * OUT_SCALE), 0, 0, 4, 4, 4);
    run_single("vec_3pi4", 1'b1, -8192, 8192, 0, 9,
               int'(19078 * OUT_SCALE), 0, 19302, 8, 4, 8);
    run_single("vec_zero", 1'b1, 0, 0, 1234, 12, 0, 0, 0, 0, 0, 0);
`ifdef CORDIC_GAIN_COMP_EN
    run_single("vec_gain", 1'b1, 16384, 0, 0, 2, 16384, 0, 0, 4, 4, 4);
`endif

    random_stream(200);

    // Fill the pipeline so the oldest sample sits in the output register, then pulse reset.
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      drive(1'b0, 4000 + i, -1000, 1000 * i, i);
      ifc.in_valid  = 1'b1;
      ifc.out_ready = 1'b0;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
    check("pre_rst_out_valid", int'(ifc.out_valid), 1, 0);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", int'(ifc.out_valid), 0, 0);
    @(negedge clk);
    reset = 1'b1;
    ifc.out_ready = 1'b1;
    #1;
    check("midrst_in_ready", int'(ifc.in_ready), 1, 0);
    ov_seen = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (ifc.out_valid) ov_seen++;
    end
    check("midrst_stale_outputs", ov_seen, 0, 0);
    run_single("post_rst", 1'b0, 9949, 0, 0, 7,
               int'(16384 * OUT_SCALE), 0, 0, 4, 4, 4);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
